// File: rtl/lamp_pkg.sv
// Shared types for the lamp output stage: fade FSM states and the default duty word.
// The controller bench imports the same definitions.
package lamp_pkg;

    localparam int DUTY_W_DEF = 8;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } fade_state_t;

    typedef logic [DUTY_W_DEF-1:0] duty_t;

    // The indicator LED is held steady while the lamp is lit or brightening.
    function automatic logic state_is_lit(input fade_state_t s);
        return (s == S_UP) || (s == S_ON);
    endfunction

endpackage

// File: rtl/lamp_pwm_gen.sv
// Free-running PWM generator.
// The duty is latched only at the period boundary, so a period never sees a mid-period duty change.
module lamp_pwm_gen #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);

    localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_MAX - DUTY_ONE;

    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [DUTY_W-1:0] r_duty_lat;
    logic              r_pwm_out;

    // Period counter, period-boundary duty latch and registered compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_duty_lat <= '0;
            r_pwm_out  <= 1'b0;
        end else begin
            r_pwm_out <= (r_pwm_cnt < r_duty_lat);
            if (r_pwm_cnt == CNT_LAST) begin
                r_pwm_cnt  <= '0;
                r_duty_lat <= duty;
            end else begin
                r_pwm_cnt  <= r_pwm_cnt + DUTY_ONE;
            end
        end
    end

    assign pwm_out = r_pwm_out;

endmodule

// File: rtl/lamp_fade_driver.sv
// Lamp output stage: soft on/off duty ramp feeding a PWM generator, plus the
// mode-indicator LED (off in auto, steady in manual+lit, blinking in manual+dark).
module lamp_fade_driver
    import lamp_pkg::*;
#(
    parameter int DUTY_W      = 8,
    parameter int RAMP_STEP_T = 40,
    parameter int BLINK_T     = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lamp_req,
    input  logic              man_mode,
    output logic              pwm_out,
    output logic              led_out,
    output logic [DUTY_W-1:0] duty,
    output logic              ramping,
    output logic              at_full
);

    localparam int STEP_W  = (RAMP_STEP_T > 1) ? $clog2(RAMP_STEP_T) : 1;
    localparam int BLINK_W = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;

    localparam logic [DUTY_W-1:0]  DUTY_ONE   = DUTY_W'(1);
    localparam logic [DUTY_W-1:0]  DUTY_MAX   = {DUTY_W{1'b1}};
    localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(RAMP_STEP_T - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_T - 1);

    fade_state_t        r_state;
    logic [DUTY_W-1:0]  r_duty;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_led_out;
    logic [DUTY_W-1:0]  w_duty_up;
    logic [DUTY_W-1:0]  w_duty_dn;

    // Saturating next duty values so the ramp can never wrap.
    always_comb begin
        w_duty_up = r_duty;
        w_duty_dn = r_duty;
        if (r_duty != DUTY_MAX) begin
            w_duty_up = r_duty + DUTY_ONE;
        end else begin
            w_duty_up = DUTY_MAX;
        end
        if (r_duty != '0) begin
            w_duty_dn = r_duty - DUTY_ONE;
        end else begin
            w_duty_dn = '0;
        end
    end

    // Fade FSM and ramp stepper; a direction change always beats a pending step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_duty     <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_step_cnt <= '0;
                    if (lamp_req) begin
                        r_state <= S_UP;
                    end
                end
                S_UP: begin
                    if (!lamp_req) begin
                        r_state    <= S_DOWN;
                        r_step_cnt <= '0;
                    end else if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        r_duty     <= w_duty_up;
                        if (w_duty_up == DUTY_MAX) begin
                            r_state <= S_ON;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + STEP_ONE;
                    end
                end
                S_ON: begin
                    r_step_cnt <= '0;
                    if (!lamp_req) begin
                        r_state <= S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (lamp_req) begin
                        r_state    <= S_UP;
                        r_step_cnt <= '0;
                    end else if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        r_duty     <= w_duty_dn;
                        if (w_duty_dn == '0) begin
                            r_state <= S_OFF;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + STEP_ONE;
                    end
                end
                default: begin
                    r_state    <= S_OFF;
                    r_duty     <= '0;
                    r_step_cnt <= '0;
                end
            endcase
        end
    end

    // Indicator LED; the blink phase restarts whenever blinking is not wanted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_out   <= 1'b0;
            r_blink_cnt <= '0;
        end else if (!man_mode) begin
            r_led_out   <= 1'b0;
            r_blink_cnt <= '0;
        end else if (state_is_lit(r_state)) begin
            r_led_out   <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_led_out   <= ~r_led_out;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
        end
    end

    lamp_pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (r_duty),
        .pwm_out (pwm_out)
    );

    assign led_out = r_led_out;
    assign duty    = r_duty;
    assign ramping = (r_state == S_UP) || (r_state == S_DOWN);
    assign at_full = (r_state == S_ON);

endmodule

// File: tb/tb_lamp_fade_driver.sv
// Bench for lamp_fade_driver: a brightness/direction reference model checked
// every cycle, directed scenarios with literal expectations, then random stimulus.
module tb_lamp_fade_driver;

    localparam int DW   = 4;
    localparam int MAXD = 15;
    localparam int RT   = 2;
    localparam int BT   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lamp_req = 1'b0;
    logic          man_mode = 1'b0;
    logic          pwm_out;
    logic          led_out;
    logic [DW-1:0] duty;
    logic          ramping;
    logic          at_full;

    int errs   = 0;
    int checks = 0;

    // Reference model: brightness level, whether it is moving and in which
    // direction, elapsed clocks of the current step, PWM period position.
    int m_d = 0, m_mov = 0, m_up = 0, m_ph = 0;
    int m_cnt = 0, m_lat = 0, m_pwm = 0;
    int m_led = 0, m_bc = 0;

    lamp_fade_driver #(
        .DUTY_W      (DW),
        .RAMP_STEP_T (RT),
        .BLINK_T     (BT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lamp_req (lamp_req),
        .man_mode (man_mode),
        .pwm_out  (pwm_out),
        .led_out  (led_out),
        .duty     (duty),
        .ramping  (ramping),
        .at_full  (at_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update on every clock edge, or immediately on reset.
    initial begin
        int od;
        int olit;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_d = 0; m_mov = 0; m_up = 0; m_ph = 0;
                m_cnt = 0; m_lat = 0; m_pwm = 0; m_led = 0; m_bc = 0;
            end else begin
                od   = m_d;
                olit = ((m_mov != 0) && (m_up != 0)) || ((m_mov == 0) && (m_d == MAXD));
                m_pwm = (m_cnt < m_lat) ? 1 : 0;
                if (m_cnt == MAXD - 1) begin
                    m_cnt = 0;
                    m_lat = od;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                if (m_mov == 0) begin
                    if (lamp_req && m_d == 0) begin
                        m_mov = 1; m_up = 1; m_ph = 0;
                    end else if (!lamp_req && m_d == MAXD) begin
                        m_mov = 1; m_up = 0; m_ph = 0;
                    end
                end else if (m_up != int'(lamp_req)) begin
                    m_up = int'(lamp_req);
                    m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                    if (m_ph == RT) begin
                        m_ph = 0;
                        if (m_up != 0) m_d = (m_d < MAXD) ? m_d + 1 : MAXD;
                        else           m_d = (m_d > 0) ? m_d - 1 : 0;
                        if (m_d == 0 || m_d == MAXD) m_mov = 0;
                    end
                end
                if (!man_mode) begin
                    m_led = 0; m_bc = 0;
                end else if (olit != 0) begin
                    m_led = 1; m_bc = 0;
                end else begin
                    m_bc = m_bc + 1;
                    if (m_bc == BT) begin
                        m_bc  = 0;
                        m_led = (m_led != 0) ? 0 : 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("duty",    int'(duty),    m_d);
            chk("pwm_out", int'(pwm_out), m_pwm);
            chk("led_out", int'(led_out), m_led);
            chk("ramping", int'(ramping), m_mov);
            chk("at_full", int'(at_full), ((m_mov == 0) && (m_d == MAXD)) ? 1 : 0);
        end
    end

    initial begin
        int hi;
        int tg;
        logic pl;

        // Reset state.
        repeat (3) tick();
        chk("rst_duty", int'(duty), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_led", int'(led_out), 0);
        chk("rst_ramping", int'(ramping), 0);
        chk("rst_at_full", int'(at_full), 0);
        #2 rst = 1'b0;
        tick();

        // Full ramp up.
        lamp_req = 1'b1;
        repeat (3) tick();
        chk("ramp_edge2_duty", int'(duty), 1);
        repeat (28) tick();
        chk("ramp_edge30_duty", int'(duty), 15);
        chk("ramp_edge30_full", int'(at_full), 1);
        repeat (32) tick();
        hi = 0;
        repeat (15) begin tick(); hi += int'(pwm_out); end
        chk("pwm_full_on", hi, 15);
        lamp_req = 1'b0;
        repeat (40) tick();
        chk("off_duty", int'(duty), 0);

        // Mid-ramp reversal.
        lamp_req = 1'b1;
        repeat (11) tick();
        chk("rev_peak_duty", int'(duty), 5);
        lamp_req = 1'b0;
        repeat (10) tick();
        chk("rev_edge9_duty", int'(duty), 1);
        chk("rev_edge9_ramping", int'(ramping), 1);
        tick();
        chk("rev_end_duty", int'(duty), 0);
        chk("rev_end_ramping", int'(ramping), 0);

        // Park at duty 5 by reversing every clock, then measure the PWM ratio.
        lamp_req = 1'b1;
        repeat (11) tick();
        repeat (45) begin lamp_req = ~lamp_req; tick(); end
        hi = 0;
        repeat (15) begin lamp_req = ~lamp_req; tick(); hi += int'(pwm_out); end
        chk("park_duty", int'(duty), 5);
        chk("pwm_ratio", hi, 5);
        lamp_req = 1'b0;
        repeat (20) tick();

        // LED blinking, steady and off.
        man_mode = 1'b1;
        tg = 0;
        pl = led_out;
        repeat (16) begin
            tick();
            if (led_out != pl) tg++;
            pl = led_out;
        end
        chk("led_toggles", tg, 4);
        lamp_req = 1'b1;
        repeat (2) tick();
        chk("led_steady", int'(led_out), 1);
        man_mode = 1'b0;
        tick();
        chk("led_auto_off", int'(led_out), 0);
        lamp_req = 1'b0;
        repeat (40) tick();

        // Reset in the middle of a ramp.
        lamp_req = 1'b1;
        repeat (15) tick();
        chk("mid_duty7", int'(duty), 7);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_duty", int'(duty), 0);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_ramping", int'(ramping), 0);
        tick();
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("restart_duty", int'(duty), 1);

        // Random stimulus against the model.
        for (int k = 0; k < 80; k++) begin
            lamp_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) man_mode = ~man_mode;
            if ($urandom_range(0, 19) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            repeat ($urandom_range(1, 45)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
